// File: rtl/alu_pwr_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_pwr_ctrl_if
// Brief    : Requester / ALU / power-switch signal bundle for alu_pwr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_pwr_ctrl_if;
    logic       op_req;
    logic       op_ack;
    logic       alu_start;
    logic       alu_busy;
    logic       force_off;
    logic       alu_pwr_en;
    logic       iso_en;
    logic       alu_rst_n;
    logic [2:0] pwr_state;

    // Controller side
    modport slave (
        input  op_req,
        input  alu_busy,
        input  force_off,
        output op_ack,
        output alu_start,
        output alu_pwr_en,
        output iso_en,
        output alu_rst_n,
        output pwr_state
    );

    // Requester / ALU / environment side
    modport master (
        output op_req,
        output alu_busy,
        output force_off,
        input  op_ack,
        input  alu_start,
        input  alu_pwr_en,
        input  iso_en,
        input  alu_rst_n,
        input  pwr_state
    );
endinterface
`default_nettype wire

// File: rtl/alu_pwr_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_pwr_ctrl
// Brief    : Power sequencer (switch / isolation / local reset) and launch
//            gate for the switchable ALU domain.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pwr_ctrl #(
    parameter int PUP_CYCLES   = 4,
    parameter int ISO_CYCLES   = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_pwr_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RAMP    = 3'd1,
        S_ACTIVE  = 3'd2,
        S_DRAIN   = 3'd3,
        S_ISOLATE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_PUP_LAST  = CNT_W'(PUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ISO_LAST  = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             pwr_en_q;
    logic             iso_en_q;
    logic             alu_rst_n_q;

    logic             w_launch;
    logic             w_idle;

    // start_q blocks back-to-back launches, covering the ALU's busy latency
    assign w_launch = (state_q == S_ACTIVE) && bus.op_req && !bus.alu_busy &&
                      !bus.force_off && !start_q;
    assign w_idle   = !(bus.op_req || bus.alu_busy || start_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_OFF: begin
                if (bus.op_req && !bus.force_off) begin
                    state_d = S_RAMP;
                    cnt_d   = '0;
                end
            end
            S_RAMP: begin
                if (cnt_q == c_PUP_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_ACTIVE: begin
                if (bus.force_off || (w_idle && cnt_q == c_IDLE_LAST)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (w_idle) begin
                    cnt_d = cnt_q + c_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (bus.op_req && !bus.force_off) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else if (!bus.alu_busy && !start_q) begin
                    state_d = S_ISOLATE;
                    cnt_d   = '0;
                end
            end
            S_ISOLATE: begin
                if (cnt_q == c_ISO_LAST) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Domain controls are registered from the next state so they change
    // together with pwr_state and never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            pwr_en_q    <= 1'b0;
            iso_en_q    <= 1'b1;
            alu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= w_launch;
            pwr_en_q    <= (state_d != S_OFF);
            iso_en_q    <= !((state_d == S_ACTIVE) || (state_d == S_DRAIN));
            alu_rst_n_q <= (state_d == S_ACTIVE) || (state_d == S_DRAIN) ||
                           (state_d == S_ISOLATE);
        end
    end

    assign bus.op_ack     = w_launch;
    assign bus.alu_start  = w_launch;
    assign bus.alu_pwr_en = pwr_en_q;
    assign bus.iso_en     = iso_en_q;
    assign bus.alu_rst_n  = alu_rst_n_q;
    assign bus.pwr_state  = state_q;

endmodule
`default_nettype wire
